load_store_unit: RTL and testbench

//  CPU-side load/store stage between execute (address = Alu out, store data = RegisterFile rs2) and MemoryUnit.

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/load_store_unit_align.sv | 59 +++++
 rtl/load_store_unit.sv | 108 ++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encodings
// and the funct3 legality check.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [2:0] LSU_IDLE   = 3'd0;
  localparam logic [2:0] LSU_LOAD   = 3'd1;
  localparam logic [2:0] LSU_RMW_RD = 3'd2;
  localparam logic [2:0] LSU_WRITE  = 3'd3;
  localparam logic [2:0] LSU_RESP   = 3'd4;
  localparam logic [2:0] LSU_ERR    = 3'd5;

  // funct3[1:0] gives the access size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic bad_funct3(input logic is_store, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_store && f3[2]);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: big-endian lane extraction with sign/zero extension for loads, and
// byte/half lane merge into the read word for SB/SH read-modify-write.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic zext);
    return zext ? {24'd0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic zext);
    return zext ? {16'd0, h} : {{16{h[15]}}, h};
  endfunction

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = word[31:24];
      2'd1:    byte_lane = word[23:16];
      2'd2:    byte_lane = word[15:8];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];

    case (funct3[1:0])
      SZ_BYTE: load_ext = ext8(byte_lane, funct3[2]);
      SZ_HALF: load_ext = ext16(half_lane, funct3[2]);
      default: load_ext = word;
    endcase

    // Untouched lanes keep the value just read from memory
    store_merged = word;
    case (funct3[1:0])
      SZ_BYTE: begin
        case (offset)
          2'd0:    store_merged[31:24] = wdata[7:0];
          2'd1:    store_merged[23:16] = wdata[7:0];
          2'd2:    store_merged[15:8]  = wdata[7:0];
          default: store_merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) store_merged[15:0]  = wdata;
        else           store_merged[31:16] = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store stage in front of a word-addressed big-endian MemoryUnit.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning them down.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, eff_addr;
  logic [2:0]        funct3_q;
  logic [15:0]       wdata_q;
  logic [DATA_W-1:0] wword_q, rdata_q;
  logic [DATA_W-1:0] load_ext, store_merged;
  logic              req_bad, accept;

  assign accept = req_valid && req_ready;

  always_comb begin
    eff_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = bad_funct3(req_write, req_funct3) ||
              ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
              ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    req_bad = bad_funct3(req_write, req_funct3);
    if (req_funct3[1:0] == SZ_HALF) eff_addr[0]   = 1'b0;
    if (req_funct3[1:0] == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          if (req_bad)                          state_d = LSU_ERR;
          else if (!req_write)                  state_d = LSU_LOAD;
          else if (req_funct3[1:0] == SZ_WORD)  state_d = LSU_WRITE;
          else                                  state_d = LSU_RMW_RD;
        end
      end
      LSU_LOAD:   state_d = LSU_RESP;
      LSU_RMW_RD: state_d = LSU_WRITE;
      LSU_WRITE:  state_d = LSU_RESP;
      default:    state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LSU_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      wword_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= eff_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata[15:0];
        // SW needs no read, so its write word is ready at accept
        if (req_write && !req_bad && (req_funct3[1:0] == SZ_WORD)) wword_q <= req_wdata;
      end
      if (state_q == LSU_LOAD)   rdata_q <= load_ext;
      if (state_q == LSU_RMW_RD) wword_q <= store_merged;
    end
  end

  lsu_align u_align (
    .word         (mem_data_out),
    .offset       (addr_q[1:0]),
    .funct3       (funct3_q),
    .wdata        (wdata_q),
    .load_ext     (load_ext),
    .store_merged (store_merged)
  );

  // Outputs gated by rst_n so a reset cycle never leaks a response or a write
  assign req_ready   = (state_q == LSU_IDLE) && rst_n;
  assign resp_valid  = ((state_q == LSU_RESP) || (state_q == LSU_ERR)) && rst_n;
  assign resp_err    = (state_q == LSU_ERR) && rst_n;
  assign mem_write   = (state_q == LSU_WRITE) && rst_n;
  assign mem_address = (state_q == LSU_IDLE) ? {req_addr[ADDR_W-1:2], 2'b00}
                                             : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_data_in = wword_q;
  assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against a byte-addressed big-endian memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];
  logic        load_mem = 1'b1;
  logic [31:0] exp_last = 32'd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'h80FF1234;
    return (32'(i) * 32'h01030507) ^ 32'h5A5AA5A5;
  endfunction

  // MemoryUnit: combinational read, write committed at the posedge
  assign mem_data_out = dmem[mem_address[9:2]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
    end else if (mem_write) begin
      dmem[mem_address[9:2]] <= mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    int k;
    k = int'(a % 4);
    return 8'((ref_mem[a[9:2]] >> (24 - 8 * k)) & 32'hFF);
  endfunction

  task automatic wbyte(input logic [31:0] a, input logic [7:0] b);
    int sh;
    sh = 24 - 8 * int'(a % 4);
    ref_mem[a[9:2]] = (ref_mem[a[9:2]] & ~(32'hFF << sh)) | (32'(b) << sh);
  endtask

  // Reference: byte-granular view of the access; updates ref_mem and exp_last
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic e_err, output int e_lat,
                       output logic [31:0] e_rdata, output int e_writes, output logic [31:0] e_waddr);
    int size;
    logic [31:0] ea;
    logic [63:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e_err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    ea    = addr - (addr % size);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % size) != 0) e_err = 1'b1;
`endif
    e_rdata  = exp_last;
    e_writes = 0;
    e_waddr  = ea - (ea % 4);
    e_lat    = 1;
    if (!e_err && !wr) begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v = v * 256 + 64'(rbyte(ea + i));
      if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      e_rdata = v[31:0];
      e_lat   = 2;
    end else if (!e_err) begin
      for (int i = 0; i < size; i++) wbyte(ea + i, 8'(wd >> (8 * (size - 1 - i))));
      e_writes = 1;
      e_lat    = (size == 4) ? 2 : 3;
    end
    exp_last = e_rdata;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
    logic e_err, err;
    int e_lat, e_writes, lat, nw, wcyc;
    logic [31:0] e_rdata, e_waddr, waddr;
    lat = 0; nw = 0; wcyc = 0; waddr = 32'd0; err = 1'bx; got = 32'hxxxxxxxx;
    model(wr, f3, addr, wd, e_err, e_lat, e_rdata, e_writes, e_waddr);
    req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    check({tag, " idle_addr"}, mem_address, {addr[31:2], 2'b00});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_write) begin nw++; wcyc = c; waddr = mem_address; end
      if (resp_valid) begin lat = c; got = resp_rdata; err = resp_err; break; end
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " err"}, 32'(err), 32'(e_err));
    check({tag, " rdata"}, got, e_rdata);
    check({tag, " nwrites"}, 32'(nw), 32'(e_writes));
    if (e_writes != 0) begin
      check({tag, " wcycle"}, 32'(wcyc), 32'(e_lat - 1));
      check({tag, " waddr"}, waddr, e_waddr);
    end
    @(posedge clk); #1;
    if (wr) check({tag, " memword"}, dmem[e_waddr[9:2]], ref_mem[e_waddr[9:2]]);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] bb_addr [3];
    logic [31:0] bb_got  [3];
    logic [31:0] w104;
    int acc, nresp;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    load_mem = 1'b0;
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst mem_write", 32'(mem_write), 32'd0);
    check("rst mem_data_in", mem_data_in, 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst ready", 32'(req_ready), 32'd1);

    // Loads from the preloaded word 80 FF 12 34
    do_req("lb100", 1'b0, 3'b000, 32'h100, 32'd0, got);
    check("lb100 lit", got, 32'hFFFFFF80);
    do_req("lbu101", 1'b0, 3'b100, 32'h101, 32'd0, got);
    check("lbu101 lit", got, 32'h000000FF);
    do_req("lh102", 1'b0, 3'b001, 32'h102, 32'd0, got);
    check("lh102 lit", got, 32'h00001234);
    do_req("lhu100", 1'b0, 3'b101, 32'h100, 32'd0, got);
    check("lhu100 lit", got, 32'h000080FF);
    do_req("lw100", 1'b0, 3'b010, 32'h100, 32'd0, got);
    check("lw100 lit", got, 32'h80FF1234);

    // Read-modify-write stores
    do_req("sb103", 1'b1, 3'b000, 32'h103, 32'h000000AB, got);
    check("sb103 lit", dmem[8'h40], 32'h80FF12AB);
    do_req("sh100", 1'b1, 3'b001, 32'h100, 32'h0000BEEF, got);
    check("sh100 lit", dmem[8'h40], 32'hBEEF12AB);
    do_req("sh101", 1'b1, 3'b001, 32'h101, 32'h00005A5A, got);
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh101 lit", dmem[8'h40], 32'hBEEF12AB);
`else
    check("sh101 lit", dmem[8'h40], 32'h5A5A12AB);
`endif

    // Store with an unsigned-load funct3 is rejected
    do_req("st_f3_100", 1'b1, 3'b100, 32'h108, 32'hCAFEF00D, got);
    check("st_f3_100 ready_after", 32'(req_ready), 32'd1);
    do_req("ld_f3_111", 1'b0, 3'b111, 32'h10C, 32'd0, got);

    // Reset during the WRITE cycle of an SW
    w104 = ref_mem[8'h41];
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("swrst write_cycle", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("swrst gated", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    exp_last = 32'd0;
    check("swrst resp_valid", 32'(resp_valid), 32'd0);
    check("swrst ready", 32'(req_ready), 32'd1);
    check("swrst rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    check("swrst resp_valid2", 32'(resp_valid), 32'd0);
    check("swrst memword", dmem[8'h41], w104);

    // Back-to-back LWs with req_valid held high
    bb_addr[0] = 32'h100; bb_addr[1] = 32'h104; bb_addr[2] = 32'h108;
    acc = 0; nresp = 0;
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = bb_addr[0]; req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid && nresp < 3) begin bb_got[nresp] = resp_rdata; nresp++; end
      if (req_valid && req_ready) acc++;
      @(posedge clk); #1;
      if (acc >= 3) req_valid = 1'b0;
      else req_addr = bb_addr[acc];
    end
    check("b2b accepts", 32'(acc), 32'd3);
    check("b2b responses", 32'(nresp), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < nresp) check($sformatf("b2b rdata%0d", i), bb_got[i], ref_mem[bb_addr[i][9:2]]);
    end
    exp_last = ref_mem[bb_addr[2][9:2]];

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic        wr;
      logic [31:0] a, wd;
      f3 = 3'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      wd = $urandom;
      do_req($sformatf("rnd%0d", n), wr, f3, a, wd, got);
    end

    for (int i = 8'h40; i < 8'h50; i++) check($sformatf("final mem[%0d]", i), dmem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
